// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between two masters.
//   requester 0 = cache controller line-fill/write-through path
//   requester 1 = MMU page-table walker
// Round-robin, non-preemptive, one transaction outstanding. A grant is
// serialised onto the memory request pulse / ready handshake. The response
// goes back only to the granted requester. All outputs are registered.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   rN_addr/rN_wdata            requester N byte address / write word
//   rN_read_req/rN_write_req    requester N request levels (write wins)
//   rN_rdata/rN_ready           requester N read line / completion pulse
//   mem_addr/mem_wdata          memory address / write word (held through WAIT)
//   mem_read_req/mem_write_req  one-cycle memory request pulses
//   mem_rdata/mem_ready         memory read line / completion pulse
//   busy                        high whenever the FSM is not IDLE
//   grant_id                    current or last granted requester
//   err                         timeout pulse, issued together with the ready
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, a WAIT watchdog
// of TIMEOUT_CYCLES cycles completes the transaction with err = 1. When
// undefined, err is constant 0 and WAIT lasts until mem_ready arrives.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int WORD_W         = 32,
  parameter int LINE_W         = 512,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [WORD_W-1:0] r0_wdata,
  input  logic              r0_read_req,
  input  logic              r0_write_req,
  output logic [LINE_W-1:0] r0_rdata,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [WORD_W-1:0] r1_wdata,
  input  logic              r1_read_req,
  input  logic              r1_write_req,
  output logic [LINE_W-1:0] r1_rdata,
  output logic              r1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_read_req,
  output logic              mem_write_req,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] pend;
  logic       last_grant;
  logic       op_wr;       // latched op of the transaction in flight
  logic       sel, sel_wr;
  logic       do_grant, do_done, do_timeout;
  logic       to_hit;

  assign pend = {r1_read_req | r1_write_req, r0_read_req | r0_write_req};

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  // Cleared while in ISSUE so it reads 0 on the first WAIT cycle; the
  // compare against T-1 makes RESP start after exactly T WAIT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              to_cnt <= '0;
    else if (state == ISSUE) to_cnt <= '0;
    else if (state == WAIT)  to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state == WAIT) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sel        = 1'b0;
    sel_wr     = 1'b0;
    do_grant   = 1'b0;
    do_done    = 1'b0;
    do_timeout = 1'b0;
    case (state)
      IDLE: if (|pend) begin
        do_grant  = 1'b1;
        // tie goes to whoever did not win last time
        sel       = (&pend) ? ~last_grant : pend[1];
        sel_wr    = sel ? r1_write_req : r0_write_req;
        state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (mem_ready) begin
          do_done   = 1'b1;
          state_nxt = RESP;
        end else if (to_hit) begin
          do_timeout = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath registers. Values are loaded one cycle ahead so that
  // the request pulse coincides with ISSUE and the ready with RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      r0_rdata      <= '0;
      r1_rdata      <= '0;
      r0_ready      <= 1'b0;
      r1_ready      <= 1'b0;
      busy          <= 1'b0;
      grant_id      <= 1'b0;
      err           <= 1'b0;
      op_wr         <= 1'b0;
      last_grant    <= 1'b1;   // requester 0 wins the first tie
    end else begin
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      r0_ready      <= 1'b0;
      r1_ready      <= 1'b0;
      err           <= 1'b0;
      busy          <= (state_nxt != IDLE);
      if (do_grant) begin
        grant_id      <= sel;
        last_grant    <= sel;
        op_wr         <= sel_wr;
        mem_addr      <= sel ? r1_addr  : r0_addr;
        mem_wdata     <= sel ? r1_wdata : r0_wdata;
        mem_write_req <= sel_wr;
        mem_read_req  <= ~sel_wr;
      end
      if (do_done | do_timeout) begin
        r0_ready <= ~grant_id;
        r1_ready <= grant_id;
        err      <= do_timeout;
      end
      // line lands in the same cycle as the ready; writes and timeouts
      // leave the requester's last line untouched
      if (do_done && !op_wr) begin
        if (grant_id) r1_rdata <= mem_rdata;
        else          r0_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester agents and a memory model drive the
// DUT; monitors record issues/responses; each test task pushes expected
// transactions into scoreboard queues and compares them against the recorded
// ones. Build with MEM_ARB_TIMEOUT_EN to add the watchdog scenario.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32, WORD_W = 32, LINE_W = 512, TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0, mem_addr;
  logic [WORD_W-1:0] r0_wdata = '0, r1_wdata = '0, mem_wdata;
  logic r0_read_req = 1'b0, r0_write_req = 1'b0, r1_read_req = 1'b0, r1_write_req = 1'b0;
  logic [LINE_W-1:0] r0_rdata, r1_rdata, mem_rdata = '0;
  logic r0_ready, r1_ready, mem_read_req, mem_write_req, mem_ready = 1'b0;
  logic busy, grant_id, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_read_req(r0_read_req), .r0_write_req(r0_write_req),
    .r0_rdata(r0_rdata), .r0_ready(r0_ready),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_read_req(r1_read_req), .r1_write_req(r1_write_req),
    .r1_rdata(r1_rdata), .r1_ready(r1_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  typedef struct packed { logic rd; logic wr; logic gid; logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] wdata; } mem_t;
  typedef struct packed { logic [1:0] id; logic err; logic [LINE_W-1:0] rdata; } rsp_t;
  typedef struct packed { logic rd; logic wr; logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] wdata; } cmd_t;

  mem_t exp_mem[$], obs_mem[$];
  rsp_t exp_rsp[$], obs_rsp[$];
  int   obs_mem_cyc[$], obs_rsp_cyc[$];
  cmd_t cmd0[$], cmd1[$];
  bit   act0 = 0, act1 = 0;
  int   cyc = 0, n_cmp = 0, n_mis = 0;
  int   mem_lat = 3;
  bit   mem_silent = 0, stray = 0;

  // memory content: 0x1000 holds 64, every other address its replicated address
  function automatic logic [LINE_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    if (a == 32'h1000) return LINE_W'(64);
    return {(LINE_W/ADDR_W){a}};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: ready mem_lat cycles after the issue cycle
  initial begin
    int cd;
    logic [ADDR_W-1:0] cd_addr;
    cd = 0; cd_addr = '0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (stray) begin stray = 0; mem_ready = 1'b1; mem_rdata = {(LINE_W/32){32'hDEADBEEF}}; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin mem_ready = 1'b1; mem_rdata = line_of(cd_addr); end
      end
      if ((mem_read_req || mem_write_req) && !mem_silent) begin cd = mem_lat; cd_addr = mem_addr; end
    end
  end

  // requester agents: hold the level until ready, then drop it
  initial begin
    cmd_t c;
    forever begin
      @(negedge clk);
      if (act0 && r0_ready) begin r0_read_req = 0; r0_write_req = 0; act0 = 0; end
      else if (!act0 && cmd0.size() > 0) begin
        c = cmd0.pop_front(); act0 = 1;
        r0_addr = c.addr; r0_wdata = c.wdata; r0_read_req = c.rd; r0_write_req = c.wr;
      end
      if (act1 && r1_ready) begin r1_read_req = 0; r1_write_req = 0; act1 = 0; end
      else if (!act1 && cmd1.size() > 0) begin
        c = cmd1.pop_front(); act1 = 1;
        r1_addr = c.addr; r1_wdata = c.wdata; r1_read_req = c.rd; r1_write_req = c.wr;
      end
    end
  end

  // monitors
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (mem_read_req || mem_write_req) begin
        obs_mem.push_back('{rd: mem_read_req, wr: mem_write_req, gid: grant_id, addr: mem_addr, wdata: mem_wdata});
        obs_mem_cyc.push_back(cyc);
      end
      if (r0_ready || r1_ready) begin
        obs_rsp.push_back('{id: (r0_ready && r1_ready) ? 2'd2 : {1'b0, r1_ready}, err: err,
                            rdata: r1_ready ? r1_rdata : r0_rdata});
        obs_rsp_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_idle(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (obs_rsp.size() >= n && !busy && !act0 && !act1 && cmd0.size() == 0 && cmd1.size() == 0) begin
        ok = 1; break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({busy, grant_id, err, r0_ready, r1_ready, mem_read_req, mem_write_req} !== 7'b0) begin
      n_mis++; $display("FAIL reset_ctrl: got %b want 0", {busy, grant_id, err, r0_ready, r1_ready, mem_read_req, mem_write_req}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== '0) begin
      n_mis++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_wdata}); end
    n_cmp++; if ((r0_rdata | r1_rdata) !== '0) begin
      n_mis++; $display("FAIL reset_rdata: got %h want 0", r0_rdata | r1_rdata); end
    rst_n = 1;
  endtask

  task automatic test_read();
    mem_t e_m, o_m; rsp_t e_r, o_r; bit ok; int lat;
    mem_lat = 3;
    exp_mem.push_back('{rd: 1, wr: 0, gid: 0, addr: 32'h1000, wdata: 32'h0});
    exp_rsp.push_back('{id: 2'd0, err: 0, rdata: line_of(32'h1000)});
    cmd0.push_back('{rd: 1, wr: 0, addr: 32'h1000, wdata: 32'h0});
    wait_idle(1, 60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL read_done: got timeout want completion"); end
    lat = (obs_mem_cyc.size() > 0 && obs_rsp_cyc.size() > 0) ? obs_rsp_cyc[0] - obs_mem_cyc[0] : -1;
    n_cmp++; if (lat != mem_lat + 1) begin n_mis++; $display("FAIL read_latency: got %0d want %0d", lat, mem_lat + 1); end
    while (exp_mem.size() > 0) begin
      e_m = exp_mem.pop_front(); o_m = (obs_mem.size() > 0) ? obs_mem.pop_front() : '1; n_cmp++;
      if (o_m !== e_m) begin n_mis++; $display("FAIL read_issue: got %h want %h", o_m, e_m); end
    end
    while (exp_rsp.size() > 0) begin
      e_r = exp_rsp.pop_front(); o_r = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : '1; n_cmp++;
      if (o_r !== e_r) begin n_mis++; $display("FAIL read_rsp: got %h want %h", o_r, e_r); end
    end
    n_cmp++; if (obs_mem.size() + obs_rsp.size() != 0) begin
      n_mis++; $display("FAIL read_extra: got %0d extra events want 0", obs_mem.size() + obs_rsp.size()); end
    obs_mem.delete(); obs_rsp.delete(); obs_mem_cyc.delete(); obs_rsp_cyc.delete();
  endtask

  task automatic test_write();
    mem_t e_m, o_m; rsp_t e_r, o_r; bit ok;
    exp_mem.push_back('{rd: 0, wr: 1, gid: 1, addr: 32'h2000, wdata: 32'hCAFEBABE});
    exp_rsp.push_back('{id: 2'd1, err: 0, rdata: '0});   // r1_rdata unchanged since reset
    cmd1.push_back('{rd: 0, wr: 1, addr: 32'h2000, wdata: 32'hCAFEBABE});
    wait_idle(1, 60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL write_done: got timeout want completion"); end
    while (exp_mem.size() > 0) begin
      e_m = exp_mem.pop_front(); o_m = (obs_mem.size() > 0) ? obs_mem.pop_front() : '1; n_cmp++;
      if (o_m !== e_m) begin n_mis++; $display("FAIL write_issue: got %h want %h", o_m, e_m); end
    end
    while (exp_rsp.size() > 0) begin
      e_r = exp_rsp.pop_front(); o_r = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : '1; n_cmp++;
      if (o_r !== e_r) begin n_mis++; $display("FAIL write_rsp: got %h want %h", o_r, e_r); end
    end
    n_cmp++; if (obs_mem.size() + obs_rsp.size() != 0) begin
      n_mis++; $display("FAIL write_extra: got %0d extra events want 0", obs_mem.size() + obs_rsp.size()); end
    n_cmp++; if (r0_rdata !== line_of(32'h1000)) begin
      n_mis++; $display("FAIL write_r0_hold: got %h want %h", r0_rdata, line_of(32'h1000)); end
    obs_mem.delete(); obs_rsp.delete(); obs_mem_cyc.delete(); obs_rsp_cyc.delete();
  endtask

  task automatic test_fairness();
    mem_t e_m, o_m; rsp_t e_r, o_r; bit ok;
    logic [ADDR_W-1:0] a [4];
    a[0] = 32'h3000; a[1] = 32'h4000; a[2] = 32'h3040; a[3] = 32'h4040;
    mem_lat = 1;   // fastest memory: minimum 3-cycle requester latency
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{rd: 1, wr: 0, gid: i[0], addr: a[i], wdata: 32'h0});
      exp_rsp.push_back('{id: {1'b0, i[0]}, err: 0, rdata: line_of(a[i])});
      if (i[0]) cmd1.push_back('{rd: 1, wr: 0, addr: a[i], wdata: 32'h0});
      else      cmd0.push_back('{rd: 1, wr: 0, addr: a[i], wdata: 32'h0});
    end
    wait_idle(4, 100, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL fair_done: got timeout want completion"); end
    n_cmp++; if (obs_rsp_cyc.size() > 0 && obs_mem_cyc.size() > 0 && obs_rsp_cyc[0] - obs_mem_cyc[0] != 2) begin
      n_mis++; $display("FAIL fair_min_latency: got %0d want 2", obs_rsp_cyc[0] - obs_mem_cyc[0]); end
    while (exp_mem.size() > 0) begin
      e_m = exp_mem.pop_front(); o_m = (obs_mem.size() > 0) ? obs_mem.pop_front() : '1; n_cmp++;
      if (o_m !== e_m) begin n_mis++; $display("FAIL fair_issue: got %h want %h", o_m, e_m); end
    end
    while (exp_rsp.size() > 0) begin
      e_r = exp_rsp.pop_front(); o_r = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : '1; n_cmp++;
      if (o_r !== e_r) begin n_mis++; $display("FAIL fair_rsp: got %h want %h", o_r, e_r); end
    end
    n_cmp++; if (obs_mem.size() + obs_rsp.size() != 0) begin
      n_mis++; $display("FAIL fair_extra: got %0d extra events want 0", obs_mem.size() + obs_rsp.size()); end
    obs_mem.delete(); obs_rsp.delete(); obs_mem_cyc.delete(); obs_rsp_cyc.delete();
    mem_lat = 3;
  endtask

  task automatic test_rw_stray();
    mem_t e_m, o_m; rsp_t e_r, o_r; bit ok, saw_busy;
    exp_mem.push_back('{rd: 0, wr: 1, gid: 0, addr: 32'h5000, wdata: 32'h12345678});
    exp_rsp.push_back('{id: 2'd0, err: 0, rdata: line_of(32'h3040)});
    cmd0.push_back('{rd: 1, wr: 1, addr: 32'h5000, wdata: 32'h12345678});
    wait_idle(1, 60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL rw_done: got timeout want completion"); end
    while (exp_mem.size() > 0) begin
      e_m = exp_mem.pop_front(); o_m = (obs_mem.size() > 0) ? obs_mem.pop_front() : '1; n_cmp++;
      if (o_m !== e_m) begin n_mis++; $display("FAIL rw_issue: got %h want %h", o_m, e_m); end
    end
    while (exp_rsp.size() > 0) begin
      e_r = exp_rsp.pop_front(); o_r = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : '1; n_cmp++;
      if (o_r !== e_r) begin n_mis++; $display("FAIL rw_rsp: got %h want %h", o_r, e_r); end
    end
    // stray memory ready while idle
    stray = 1; saw_busy = 0;
    repeat (5) begin @(negedge clk); #1; saw_busy |= busy; end
    n_cmp++; if (saw_busy || obs_mem.size() + obs_rsp.size() != 0) begin
      n_mis++; $display("FAIL stray_ready: got busy=%0d events=%0d want 0/0", saw_busy, obs_mem.size() + obs_rsp.size()); end
    obs_mem.delete(); obs_rsp.delete(); obs_mem_cyc.delete(); obs_rsp_cyc.delete();
  endtask

  task automatic test_reset_wait();
    mem_t e_m, o_m; rsp_t e_r, o_r; bit ok;
    mem_silent = 1;
    cmd0.push_back('{rd: 1, wr: 0, addr: 32'h6000, wdata: 32'h0});
    for (int i = 0; i < 20 && obs_mem.size() == 0; i++) begin @(negedge clk); #1; end
    n_cmp++; if (obs_mem.size() != 1) begin n_mis++; $display("FAIL abort_issue: got %0d issues want 1", obs_mem.size()); end
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({busy, grant_id, err, r0_ready, r1_ready, mem_read_req, mem_write_req} !== 7'b0 || mem_addr !== '0) begin
      n_mis++; $display("FAIL abort_async_ctrl: got %b addr %h want 0", {busy, grant_id, err, r0_ready, r1_ready, mem_read_req, mem_write_req}, mem_addr); end
    n_cmp++; if (r0_rdata !== '0) begin n_mis++; $display("FAIL abort_async_rdata: got %h want 0", r0_rdata); end
    r0_read_req = 0; act0 = 0; cmd0.delete(); mem_silent = 0;
    obs_mem.delete(); obs_rsp.delete(); obs_mem_cyc.delete(); obs_rsp_cyc.delete();
    @(negedge clk); rst_n = 1;
    exp_mem.push_back('{rd: 1, wr: 0, gid: 1, addr: 32'h7000, wdata: 32'h0});
    exp_rsp.push_back('{id: 2'd1, err: 0, rdata: line_of(32'h7000)});
    cmd1.push_back('{rd: 1, wr: 0, addr: 32'h7000, wdata: 32'h0});
    wait_idle(1, 60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL after_abort_done: got timeout want completion"); end
    while (exp_mem.size() > 0) begin
      e_m = exp_mem.pop_front(); o_m = (obs_mem.size() > 0) ? obs_mem.pop_front() : '1; n_cmp++;
      if (o_m !== e_m) begin n_mis++; $display("FAIL after_abort_issue: got %h want %h", o_m, e_m); end
    end
    while (exp_rsp.size() > 0) begin
      e_r = exp_rsp.pop_front(); o_r = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : '1; n_cmp++;
      if (o_r !== e_r) begin n_mis++; $display("FAIL after_abort_rsp: got %h want %h", o_r, e_r); end
    end
    n_cmp++; if (obs_mem.size() + obs_rsp.size() != 0) begin
      n_mis++; $display("FAIL abort_extra: got %0d extra events want 0", obs_mem.size() + obs_rsp.size()); end
    obs_mem.delete(); obs_rsp.delete(); obs_mem_cyc.delete(); obs_rsp_cyc.delete();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    rsp_t e_r, o_r; bit ok; int lat;
    mem_silent = 1;
    exp_rsp.push_back('{id: 2'd0, err: 1, rdata: '0});   // r0 line cleared by the earlier reset
    cmd0.push_back('{rd: 1, wr: 0, addr: 32'h8000, wdata: 32'h0});
    wait_idle(1, 60, ok);
    n_cmp++; if (!ok) begin n_mis++; $display("FAIL timeout_done: got no completion want err ready"); end
    lat = (obs_mem_cyc.size() > 0 && obs_rsp_cyc.size() > 0) ? obs_rsp_cyc[0] - obs_mem_cyc[0] : -1;
    n_cmp++; if (lat != TO + 1) begin n_mis++; $display("FAIL timeout_latency: got %0d want %0d", lat, TO + 1); end
    while (exp_rsp.size() > 0) begin
      e_r = exp_rsp.pop_front(); o_r = (obs_rsp.size() > 0) ? obs_rsp.pop_front() : '1; n_cmp++;
      if (o_r !== e_r) begin n_mis++; $display("FAIL timeout_rsp: got %h want %h", o_r, e_r); end
    end
    stray = 1; mem_silent = 0;   // late memory answer
    repeat (5) @(negedge clk);
    #1;
    n_cmp++; if (obs_rsp.size() != 0 || busy || r0_rdata !== '0) begin
      n_mis++; $display("FAIL timeout_late_ready: got rsp=%0d busy=%0d want 0/0", obs_rsp.size(), busy); end
    obs_mem.delete(); obs_rsp.delete(); obs_mem_cyc.delete(); obs_rsp_cyc.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_fairness();
    test_rw_stray();
    test_reset_wait();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish");
    $fatal(1);
  end

endmodule
